uart_tx: RTL and testbench

- UART transmitter, the partner of the team's oversampled UART receiver. Uses the same 16x `s_tick` baud generator and the same frame format: 1 start bit, DBIT data bits LSB first, then stop bits of SB_TICK ticks.
- Serializes a parallel word onto `tx`.
- A one-entry holding register lets the host queue the next word while the current frame is shifting, giving back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter with a one-entry holding register.
// Frame: start bit, DBIT data bits LSB first, optional parity, SB_TICK-tick stop.
// Optional parity stage is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [4:0] TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    // Parity bit sent after the data bits; PAR_ODD selects odd sense.
    function automatic logic frame_parity(input logic [DBIT-1:0] word);
        return (^word) ^ (PAR_ODD != 0);
    endfunction
`endif

    state_t            state_r;
    state_t            state_s;
    logic [4:0]        s_r;
    logic [4:0]        s_s;
    logic [2:0]        n_r;
    logic [2:0]        n_s;
    logic [DBIT-1:0]   b_r;
    logic [DBIT-1:0]   b_s;
    logic [DBIT-1:0]   hold_r;
    logic [DBIT-1:0]   hold_s;
    logic              hold_valid_r;
    logic              hold_valid_s;
    logic              tx_r;
    logic              tx_s;
    logic              ready_r;
    logic              busy_r;
    logic              accept_s;
    logic              load_s;
    logic [DBIT-1:0]   load_word_s;
    logic              hold_take_s;
    logic              done_s;
`ifdef UART_TX_PARITY_EN
    logic              par_r;
    logic              par_s;
`endif

    assign accept_s     = tx_start & ready_r;
    assign tx_ready     = ready_r;
    assign tx_busy      = busy_r;
    assign tx           = tx_r;
    assign tx_done_tick = done_s & ~reset;

    // Frame sequencer: next state, tick/bit counters and shifter load/shift.
    always_comb begin
        state_s     = state_r;
        s_s         = s_r;
        n_s         = n_r;
        b_s         = b_r;
        load_s      = 1'b0;
        load_word_s = din;
        hold_take_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s  = 1'b1;
                    b_s     = din;
                    s_s     = 5'd0;
                    state_s = ST_START;
                end else begin
                    s_s     = 5'd0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_r == TICK_LAST) begin
                        s_s     = 5'd0;
                        n_s     = 3'd0;
                        state_s = ST_DATA;
                    end else begin
                        s_s = s_r + 5'd1;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_r == TICK_LAST) begin
                        s_s = 5'd0;
                        b_s = b_r >> 1;
                        if (n_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_s = ST_PARITY;
`else
                            state_s = ST_STOP;
`endif
                        end else begin
                            n_s = n_r + 3'd1;
                        end
                    end else begin
                        s_s = s_r + 5'd1;
                    end
                end else begin
                    s_s = s_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_r == TICK_LAST) begin
                        s_s     = 5'd0;
                        state_s = ST_STOP;
                    end else begin
                        s_s = s_r + 5'd1;
                    end
                end else begin
                    s_s = s_r;
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_r == STOP_LAST) begin
                        done_s = 1'b1;
                        s_s    = 5'd0;
                        if (hold_valid_r) begin
                            // Queued word goes straight into the next start bit.
                            load_s      = 1'b1;
                            load_word_s = hold_r;
                            b_s         = hold_r;
                            hold_take_s = 1'b1;
                            state_s     = ST_START;
                        end else if (accept_s) begin
                            load_s  = 1'b1;
                            b_s     = din;
                            state_s = ST_START;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        s_s = s_r + 5'd1;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                s_s     = 5'd0;
                n_s     = 3'd0;
            end
        endcase
    end

    // Holding register: capture a write that cannot enter the shifter, release it on reload.
    always_comb begin
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        if (hold_take_s) begin
            hold_valid_s = 1'b0;
        end else if (accept_s && !load_s) begin
            hold_s       = din;
            hold_valid_s = 1'b1;
        end else begin
            hold_valid_s = hold_valid_r;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the word entering the shifter, frozen for the whole frame.
    always_comb begin
        if (load_s) begin
            par_s = frame_parity(load_word_s);
        end else begin
            par_s = par_r;
        end
    end
`endif

    // Line level for the state being entered, so the tx flop changes exactly at boundaries.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = b_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_s = par_s;
`endif
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            s_r          <= 5'd0;
            n_r          <= 3'd0;
            b_r          <= '0;
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            tx_r         <= 1'b1;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            s_r          <= s_s;
            n_r          <= n_s;
            b_r          <= b_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            tx_r         <= tx_s;
            ready_r      <= ~hold_valid_s;
            busy_r       <= (state_s != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            par_r        <= par_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: the line is sampled once per s_tick and
// compared against a tick-level reference stream built from accepted words.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DBIT     = 8;
    localparam int SB_MAIN  = 16;
    localparam int SB_LONG  = 32;
    localparam int PAR_MAIN = 0;
    localparam int PAR_LONG = 1;
    localparam int BUDGET   = 20000;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       s_tick     = 1'b0;
    logic       tx_start   = 1'b0;
    logic [7:0] din        = 8'h00;
    logic       tx_start32 = 1'b0;
    logic [7:0] din32      = 8'h00;
    logic       tx_ready, tx_busy, tx_done_tick, tx;
    logic       tx_ready32, tx_busy32, tx_done32, tx32;

    int vectors     = 0;
    int miscompares = 0;
    int tick_period = 4;

    logic got_q[$];
    int   done_q[$];
    logic exp_q[$];
    int   exp_done_q[$];
    logic long_q[$];
    int   long_done = -1;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_MAIN), .PAR_ODD(PAR_MAIN)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_LONG), .PAR_ODD(PAR_LONG)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start32), .din(din32),
        .tx_ready(tx_ready32), .tx_busy(tx_busy32), .tx_done_tick(tx_done32), .tx(tx32)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk wide every tick_period clocks.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= tick_period - 1) begin
                s_tick = 1'b1;
                cnt    = 0;
            end else begin
                s_tick = 1'b0;
                cnt    = cnt + 1;
            end
        end
    end

    // Line monitor: one sample per tick, done pulses recorded as tick positions.
    always @(negedge clk) begin
        if (s_tick) got_q.push_back(tx);
        if (tx_done_tick) done_q.push_back(got_q.size());
        if (s_tick) long_q.push_back(tx32);
        if (tx_done32 && long_done < 0) long_done = long_q.size();
    end

    // Reference: a frame accepted after k samples starts at tick k, or right after the previous frame.
    function automatic void model_frame(input logic [7:0] w, input int k);
        while (exp_q.size() < k) exp_q.push_back(1'b1);
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) repeat (16) exp_q.push_back(w[i]);
        for (int p = 0; p < PAR_SLOTS; p++) repeat (16) exp_q.push_back((^w) ^ (PAR_MAIN != 0));
        repeat (SB_MAIN) exp_q.push_back(1'b1);
        exp_done_q.push_back(exp_q.size());
    endfunction

    // Number of sampled ticks differing from the reference (idle high beyond its end).
    function automatic int stream_errors(output int first_idx);
        int   errs;
        logic e;
        errs      = 0;
        first_idx = -1;
        for (int i = 0; i < got_q.size(); i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            if (got_q[i] !== e) begin
                if (errs == 0) first_idx = i;
                errs++;
            end
        end
        if (got_q.size() < exp_q.size()) errs = errs + (exp_q.size() - got_q.size());
        return errs;
    endfunction

    task automatic clear_streams();
        got_q.delete();
        done_q.delete();
        exp_q.delete();
        exp_done_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_start = 1'b1; din = 8'hA5; tx_start32 = 1'b1; din32 = 8'h5A;
        repeat (3) @(negedge clk);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, expected 1", tx_ready); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", tx_busy); end
        vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", tx_done_tick); end
        vectors++; if (tx32 !== 1'b1 || tx_busy32 !== 1'b0) begin miscompares++; $display("FAIL reset_long: tx %b busy %b, expected 1 0", tx32, tx_busy32); end
        @(posedge clk); #1;
        reset = 1'b0; tx_start = 1'b0; tx_start32 = 1'b0;
        @(negedge clk);
        vectors++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_release: tx %b busy %b, expected 1 0", tx, tx_busy); end
    endtask

    task automatic check_stream_and_done(input string tag);
        int c, fi, errs;
        for (c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (got_q.size() >= exp_q.size() + 8) break;
        end
        vectors++;
        if (got_q.size() < exp_q.size() + 8) begin
            miscompares++; $display("FAIL %s_timeout: ticks seen %0d, expected %0d", tag, got_q.size(), exp_q.size() + 8);
        end
        errs = stream_errors(fi);
        vectors++;
        if (errs !== 0) begin
            miscompares++; $display("FAIL %s_stream: %0d bad ticks, first at tick %0d, expected 0 bad ticks", tag, errs, fi);
        end
        vectors++;
        if (done_q.size() !== exp_done_q.size()) begin
            miscompares++; $display("FAIL %s_done_count: got %0d, expected %0d", tag, done_q.size(), exp_done_q.size());
        end else begin
            for (int j = 0; j < exp_done_q.size(); j++) begin
                vectors++;
                if (done_q[j] !== exp_done_q[j]) begin
                    miscompares++; $display("FAIL %s_done_pos%0d: got tick %0d, expected %0d", tag, j, done_q[j], exp_done_q[j]);
                end
            end
        end
    endtask

    task automatic test_single();
        int c;
        bit found;
        @(posedge clk); #1;
        clear_streams();
        tx_start = 1'b1; din = 8'hA5;
        @(negedge clk);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_pre_tx: got %b, expected 1", tx); end
        @(posedge clk); #1;
        tx_start = 1'b0;
        model_frame(8'hA5, got_q.size());
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_latency: got %b, expected 0", tx); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, expected 1", tx_busy); end
        found = 1'b0;
        for (c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL single_done_timeout: got no pulse, expected one"); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_at_done: got %b, expected 1", tx_busy); end
        @(negedge clk);
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b, expected 0", tx_busy); end
        vectors++; if (tx_done_tick !== 1'b0) begin miscompares++; $display("FAIL single_done_width: got %b, expected 0", tx_done_tick); end
        check_stream_and_done("single");
    endtask

    task automatic test_back_to_back();
        int c;
        bit found;
        @(posedge clk); #1;
        clear_streams();
        tx_start = 1'b1; din = 8'h3C;
        @(posedge clk); #1;
        tx_start = 1'b0;
        model_frame(8'h3C, got_q.size());
        repeat (10) @(posedge clk);
        #1; tx_start = 1'b1; din = 8'hC3;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_before: got %b, expected 1", tx_ready); end
        @(posedge clk); #1;
        tx_start = 1'b0;
        model_frame(8'hC3, got_q.size());
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop: got %b, expected 0", tx_ready); end
        tx_start = 1'b1; din = 8'h55;
        @(negedge clk);
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b, expected 0", tx_ready); end
        @(posedge clk); #1;
        tx_start = 1'b0;
        found = 1'b0;
        for (c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin found = 1'b1; break; end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL b2b_done_timeout: got no pulse, expected one"); end
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_at_done: got %b, expected 0", tx_ready); end
        @(posedge clk); #1;
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_return: got %b, expected 1", tx_ready); end
        vectors++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reload: tx %b busy %b, expected 0 1", tx, tx_busy); end
        check_stream_and_done("b2b");
    endtask

    task automatic test_reset_mid();
        int c, k0, lows, dones;
        @(posedge clk); #1;
        clear_streams();
        tx_start = 1'b1; din = 8'hFF;
        @(posedge clk); #1;
        tx_start = 1'b0;
        k0 = got_q.size();
        repeat (10) @(posedge clk);
        #1; tx_start = 1'b1; din = 8'h81;
        @(posedge clk); #1;
        tx_start = 1'b0;
        for (c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (got_q.size() >= k0 + 16 + 3 * 16 + 8) break;
        end
        vectors++;
        if (got_q.size() < k0 + 72) begin miscompares++; $display("FAIL mid_timeout: ticks %0d, expected %0d", got_q.size(), k0 + 72); end
        @(posedge clk); #1;
        reset = 1'b1; tx_start = 1'b1; din = 8'h5A;
        @(posedge clk); #1;
        reset = 1'b0; tx_start = 1'b0;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_tx: got %b, expected 1", tx); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b, expected 0", tx_busy); end
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b, expected 1", tx_ready); end
        lows = 0; dones = 0;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (tx_done_tick !== 1'b0) dones++;
        end
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL mid_line_idle: %0d low cycles, expected 0", lows); end
        vectors++; if (dones !== 0 || done_q.size() !== 0) begin miscompares++; $display("FAIL mid_no_done: %0d pulses, expected 0", dones + done_q.size()); end
    endtask

    task automatic test_sb32();
        int c, k, len, ones, run;
        @(posedge clk); #1;
        long_q.delete();
        long_done = -1;
        tx_start32 = 1'b1; din32 = 8'h07;
        @(posedge clk); #1;
        tx_start32 = 1'b0;
        k = long_q.size();
        for (c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (long_done >= 0) break;
        end
        vectors++; if (long_done < 0) begin miscompares++; $display("FAIL sb32_timeout: got no done, expected one"); end
        @(negedge clk);
        vectors++; if (tx_busy32 !== 1'b0) begin miscompares++; $display("FAIL sb32_busy: got %b, expected 0", tx_busy32); end
        if (long_done >= 0) begin
            len = long_done - k;
            vectors++;
            if (len !== 16 * (1 + DBIT + PAR_SLOTS) + SB_LONG) begin
                miscompares++; $display("FAIL sb32_length: got %0d ticks, expected %0d", len, 16 * (1 + DBIT + PAR_SLOTS) + SB_LONG);
            end
            ones = 0;
            for (int i = k; i < long_done; i++) if (long_q[i] === 1'b1) ones++;
            vectors++;
            if (ones !== 3 * 16 + SB_LONG) begin miscompares++; $display("FAIL sb32_high_ticks: got %0d, expected %0d", ones, 3 * 16 + SB_LONG); end
            run = 0;
            for (int i = long_done - 1; i >= k && long_q[i] === 1'b1; i--) run++;
            vectors++;
            if (run !== SB_LONG) begin miscompares++; $display("FAIL sb32_stop_ticks: got %0d, expected %0d", run, SB_LONG); end
        end
    endtask

    task automatic test_random();
        int c, gap;
        bit ok;
        logic [7:0] w;
        tick_period = $urandom_range(1, 6);
        @(posedge clk); #1;
        clear_streams();
        for (int f = 0; f < 8; f++) begin
            w   = (f == 0) ? 8'h07 : 8'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 1500) : $urandom_range(0, 40);
            repeat (gap) @(posedge clk);
            #1; tx_start = 1'b1; din = w;
            ok = 1'b0;
            for (c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (tx_ready === 1'b1) begin ok = 1'b1; break; end
            end
            @(posedge clk); #1;
            tx_start = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL rand_ready_timeout: frame %0d not accepted, expected acceptance", f);
            end else begin
                model_frame(w, got_q.size());
            end
        end
        check_stream_and_done("rand");
        tick_period = 4;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_sb32();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
